// File: rtl/ariane_pkg.sv
// ariane_pkg -- shared types for the runtime-monitor event log.
//
// Holds the log record layout (rm_log_entry_t), the record-kind encodings
// and a saturating add used by the optional drop counter.
package ariane_pkg;

    // Record field widths. The lane field has to be wide enough for the
    // router's lane count (clog2(NUM_LANES), minimum 1 bit). A narrower
    // timestamp counter is zero-extended into the ts field.
    localparam int RM_LOG_LANE_W = 2;
    localparam int RM_LOG_TS_W   = 16;

    localparam logic RM_LOG_KIND_MATCH = 1'b0;
    localparam logic RM_LOG_KIND_RESET = 1'b1;

    typedef struct packed {
        logic                     kind;
        logic [RM_LOG_LANE_W-1:0] lane;
        logic [RM_LOG_TS_W-1:0]   ts;
    } rm_log_entry_t;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] rm_sat_add16(input logic [15:0] a,
                                                 input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/rm_log_fifo.sv
// rm_log_fifo -- register-array FIFO for event-log records.
//
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate occupancy register. The head slot is read
// combinationally, so there is no read latency.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   flush_i       synchronous flush of both pointers (beats push and pop)
//   push_i/data_i write a record; ignored when full
//   pop_i         retire the head; ignored when empty
//   data_o        head record (stale contents when empty)
//   full_o/empty_o occupancy flags
//   count_o       occupancy, from the registered pointers
module rm_log_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, rptr_q;
    T            mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A pop frees a slot only from the next cycle on, so a push is gated
    // by the current full flag and never by a same-cycle pop.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // The storage is reset as well, so the head reads as zero after reset.
    // A flush leaves the contents alone; only the pointers matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/rm_lane_event_log.sv
// rm_lane_event_log -- time-stamped capture of per-lane router events.
//
// Each lane completion or lane reset from the event router raises a pending
// flag. One flag per cycle is turned into a {kind, lane, ts} record and
// pushed into a small FIFO that software or a debug module drains. Resets
// beat matches, and lower lanes beat higher ones. While the FIFO is full,
// flags simply stay pending, which backpressures the log. An event that
// lands on a flag that is already pending is dropped.
//
// Build option: define RM_EVENT_LOG_DROP_CNT_EN to add a saturating 16-bit
// dropped-event counter and its drop_cnt_o port.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   lane_vector_i  per-lane completion pulses
//   lane_reset_i   per-lane reset pulses
//   clear_i        synchronous flush of the FIFO, flags, timestamp and drop count
//   log_valid_o    FIFO head valid
//   log_ready_i    consumer takes the head
//   log_entry_o    head record
//   count_o        FIFO occupancy
//   drop_cnt_o     dropped-event count (only with RM_EVENT_LOG_DROP_CNT_EN)
module rm_lane_event_log
    import ariane_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_LANES-1:0]   lane_vector_i,
    input  logic [NUM_LANES-1:0]   lane_reset_i,
    input  logic                   clear_i,
    output logic                   log_valid_o,
    input  logic                   log_ready_i,
    output rm_log_entry_t          log_entry_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef RM_EVENT_LOG_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt_o
`endif
);

    localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [NUM_LANES-1:0]  match_pend_q, reset_pend_q;
    logic [NUM_LANES-1:0]  match_clr, reset_clr;
    logic [LANE_IDX_W-1:0] sel_idx;
    logic                  sel_kind;
    logic                  push;
    logic                  fifo_full, fifo_empty;
    logic [TS_W-1:0]       ts_q;
    rm_log_entry_t         push_entry;

    // Priority arbiter. Scanning from the top lane down leaves the lowest
    // set index in sel_idx. The per-lane clear masks are one-hot, or all
    // zero when nothing is pushed.
    always_comb begin
        sel_idx   = '0;
        sel_kind  = RM_LOG_KIND_MATCH;
        match_clr = '0;
        reset_clr = '0;
        if (|reset_pend_q) begin
            sel_kind = RM_LOG_KIND_RESET;
            for (int k = NUM_LANES - 1; k >= 0; k--)
                if (reset_pend_q[k]) sel_idx = LANE_IDX_W'(k);
        end else begin
            for (int k = NUM_LANES - 1; k >= 0; k--)
                if (match_pend_q[k]) sel_idx = LANE_IDX_W'(k);
        end
        push = (|reset_pend_q || |match_pend_q) && !fifo_full && !clear_i;
        if (push) begin
            if (sel_kind == RM_LOG_KIND_RESET) reset_clr[sel_idx] = 1'b1;
            else                               match_clr[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.kind = sel_kind;
        push_entry.lane = RM_LOG_LANE_W'(sel_idx);
        push_entry.ts   = RM_LOG_TS_W'(ts_q);
    end

    // A new event in the same cycle as its flag's push re-arms the flag:
    // the push clears it first, then the event ORs it back in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            match_pend_q <= '0;
            reset_pend_q <= '0;
        end else if (clear_i) begin
            match_pend_q <= '0;
            reset_pend_q <= '0;
        end else begin
            match_pend_q <= (match_pend_q & ~match_clr) | lane_vector_i;
            reset_pend_q <= (reset_pend_q & ~reset_clr) | lane_reset_i;
        end
    end

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        ts_q <= '0;
        else if (clear_i) ts_q <= '0;
        else              ts_q <= ts_q + 1'b1;
    end

    rm_log_fifo #(
        .T     (rm_log_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (clear_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (log_valid_o && log_ready_i),
        .data_o  (log_entry_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign log_valid_o = !fifo_empty;

`ifdef RM_EVENT_LOG_DROP_CNT_EN
    // An event is dropped when its flag is already set and is not being
    // cleared by this cycle's push.
    logic [NUM_LANES-1:0] drop_match, drop_reset;
    logic [15:0]          drop_num;
    logic [15:0]          drop_cnt_q;

    assign drop_match = lane_vector_i & match_pend_q & ~match_clr;
    assign drop_reset = lane_reset_i  & reset_pend_q & ~reset_clr;

    always_comb begin
        drop_num = '0;
        for (int k = 0; k < NUM_LANES; k++)
            drop_num = drop_num + 16'(drop_match[k]) + 16'(drop_reset[k]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        drop_cnt_q <= '0;
        else if (clear_i) drop_cnt_q <= '0;
        else              drop_cnt_q <= rm_sat_add16(drop_cnt_q, drop_num);
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
